fire_expand_sched: RTL and testbench

//  Sequencer for one 1x1 fire expand layer. Handles start/done with the previous layer.

---
 rtl/fire_pkg.sv | 10 +
 rtl/fire_expand_sched_if.sv | 27 ++
 rtl/fire_ifm_addr_gen.sv | 56 +++++
 rtl/fire_expand_sched.sv | 84 ++++++++
 tb/tb_fire_expand_sched.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fire_pkg.sv
// fire_pkg: shared state type, default geometry and ifm address helper
// for the fire expand layer scheduler.
package fire_pkg;
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WAITWB, DONE} sched_state_t;
    localparam int WOUT_DEF = 16;
    localparam int CHIN_DEF = 64;
    function automatic int unsigned addr_of(int unsigned ch, int unsigned pix, int unsigned npix);
        return ch * npix + pix;
    endfunction
endpackage

// File: rtl/fire_expand_sched_if.sv
// fire_expand_sched_if: start/done handshake, ifm read port and datapath
// strobes of one expand layer; master is the surrounding system, slave the scheduler.
interface fire_expand_sched_if #(
    parameter int WOUT = fire_pkg::WOUT_DEF,
    parameter int CHIN = fire_pkg::CHIN_DEF
);
    localparam int ADDR_W = $clog2(WOUT**2*CHIN);
    localparam int CNT_W  = $clog2(WOUT**2)+1;
    logic              start_i;
    logic              ifm_rd_en_o;
    logic [ADDR_W-1:0] ifm_rd_addr_o;
    logic              layer_en_o;
    logic              sample_i;
    logic              ram_feedback_i;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  pix_cnt_o;
    logic              err_o;
    modport master (
        output start_i, sample_i, ram_feedback_i,
        input  ifm_rd_en_o, ifm_rd_addr_o, layer_en_o, busy_o, done_o, pix_cnt_o, err_o
    );
    modport slave (
        input  start_i, sample_i, ram_feedback_i,
        output ifm_rd_en_o, ifm_rd_addr_o, layer_en_o, busy_o, done_o, pix_cnt_o, err_o
    );
endinterface

// File: rtl/fire_ifm_addr_gen.sv
// fire_ifm_addr_gen: channel-major ifm address walk, CHIN reads then one
// bubble per pixel slot; flags the bubble of the final pixel.
module fire_ifm_addr_gen
    import fire_pkg::*;
#(
    parameter int WOUT = WOUT_DEF,
    parameter int CHIN = CHIN_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_load,
    input  logic                             i_step,
    output logic                             o_rd_en,
    output logic [$clog2(WOUT**2*CHIN)-1:0]  o_addr,
    output logic                             o_last_slot
);
    localparam int NPIX   = WOUT**2;
    localparam int ADDR_W = $clog2(NPIX*CHIN);
    localparam int CW     = $clog2(CHIN+1);
    localparam int PW     = $clog2(NPIX+1);
    logic [CW-1:0] r_ch;
    logic [PW-1:0] r_pix;
    logic          r_bubble;
    logic          r_last;
    logic          w_ch_end;
    logic          w_pix_end;
    assign w_ch_end    = r_ch == CW'(CHIN-1);
    assign w_pix_end   = r_pix == PW'(NPIX-1);
    assign o_last_slot = r_bubble & r_last;
    always_ff @(posedge clk) begin
        if (!rst || i_load) begin
            r_ch     <= '0;
            r_pix    <= '0;
            r_bubble <= 1'b0;
            r_last   <= 1'b0;
            o_rd_en  <= rst && i_load;
            o_addr   <= '0;
        end else if (i_step) begin
            if (r_bubble) begin
                r_bubble <= 1'b0;
                o_rd_en  <= !r_last;
                o_addr   <= r_last ? o_addr : ADDR_W'(addr_of(0, 32'(r_pix), NPIX));
            end else if (w_ch_end) begin
                // pixel advances during the bubble; the address holds until the next read
                r_ch     <= '0;
                r_pix    <= w_pix_end ? '0 : r_pix + PW'(1);
                r_bubble <= 1'b1;
                r_last   <= w_pix_end;
                o_rd_en  <= 1'b0;
            end else begin
                r_ch   <= r_ch + CW'(1);
                o_addr <= ADDR_W'(addr_of(32'(r_ch) + 1, 32'(r_pix), NPIX));
            end
        end
    end
endmodule

// File: rtl/fire_expand_sched.sv
// fire_expand_sched: start/done sequencer for one 1x1 fire expand layer;
// counts datapath samples and holds done until write-back is confirmed.
module fire_expand_sched
    import fire_pkg::*;
#(
    parameter int WOUT = WOUT_DEF,
    parameter int CHIN = CHIN_DEF
) (
    input logic                clk,
    input logic                rst,
    fire_expand_sched_if.slave bus
);
    localparam int NPIX  = WOUT**2;
    localparam int CNT_W = $clog2(NPIX)+1;
    sched_state_t     r_state;
    logic             r_busy;
    logic             r_layer_en;
    logic             r_done;
    logic             r_fb;
    logic             r_err;
    logic [CNT_W-1:0] r_pix_cnt;
    logic             w_accept;
    logic             w_step;
    logic             w_last_slot;
    logic             w_full;
    logic             w_counting;
    assign w_accept   = r_state == IDLE && bus.start_i;
    assign w_step     = r_state == RUN;
    assign w_full     = r_pix_cnt == CNT_W'(NPIX);
    assign w_counting = r_state == RUN || r_state == DRAIN;
    fire_ifm_addr_gen #(.WOUT(WOUT), .CHIN(CHIN)) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_step      (w_step),
        .o_rd_en     (bus.ifm_rd_en_o),
        .o_addr      (bus.ifm_rd_addr_o),
        .o_last_slot (w_last_slot)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_layer_en <= 1'b0;
            r_done     <= 1'b0;
            r_fb       <= 1'b0;
            r_err      <= 1'b0;
            r_pix_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.ram_feedback_i && r_state inside {RUN, DRAIN, WAITWB})
                r_fb <= 1'b1;
            if (bus.sample_i && w_counting && !w_full)
                r_pix_cnt <= r_pix_cnt + CNT_W'(1);
            if ((bus.sample_i && (!w_counting || w_full)) || (bus.ram_feedback_i && r_state == IDLE))
                r_err <= 1'b1;
            case (r_state)
                IDLE: if (bus.start_i) begin
                    r_state    <= RUN;
                    r_busy     <= 1'b1;
                    r_layer_en <= 1'b1;
                    r_pix_cnt  <= '0;
                end
                RUN: if (w_last_slot) begin
                    r_state    <= DRAIN;
                    r_layer_en <= 1'b0;
                end
                DRAIN: if (w_full) r_state <= WAITWB;
                WAITWB: if (r_fb) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_fb    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.layer_en_o = r_layer_en;
    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.pix_cnt_o  = r_pix_cnt;
    assign bus.err_o      = r_err;
endmodule

// File: tb/tb_fire_expand_sched.sv
// tb_fire_expand_sched: directed table and hand sequences for the expand-layer
// scheduler; instance a is WOUT=2/CHIN=4, instance b is WOUT=3/CHIN=5.
module tb_fire_expand_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fire_expand_sched_if #(.WOUT(2), .CHIN(4)) a_if ();
    fire_expand_sched_if #(.WOUT(3), .CHIN(5)) b_if ();
    fire_expand_sched #(.WOUT(2), .CHIN(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    fire_expand_sched #(.WOUT(3), .CHIN(5)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    typedef struct {
        int st, sm, fb;
        int rd, addr, en, busy, done, cnt;
    } vec_t;

    vec_t tv[27];
    int n_chk = 0;
    int n_pass = 0;

    function automatic vec_t v(int st, int sm, int fb, int rd, int addr, int en, int busy, int done, int cnt);
        vec_t r;
        r.st = st; r.sm = sm; r.fb = fb;
        r.rd = rd; r.addr = addr; r.en = en; r.busy = busy; r.done = done; r.cnt = cnt;
        return r;
    endfunction

    // expected read strobe / address for RUN cycle k of a layer
    function automatic int e_rd(int k, int chin);
        return (k % (chin + 1)) != chin ? 1 : 0;
    endfunction
    function automatic int e_addr(int k, int chin, int npix);
        int ch = k % (chin + 1);
        int pix = k / (chin + 1);
        return (ch == chin ? chin - 1 : ch) * npix + pix;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input logic st, input logic stb, input logic sm, input logic fb);
        a_if.start_i = st;
        b_if.start_i = stb;
        a_if.sample_i = sm;
        a_if.ram_feedback_i = fb;
        @(posedge clk);
        #1;
        a_if.start_i = 1'b0;
        b_if.start_i = 1'b0;
        a_if.sample_i = 1'b0;
        a_if.ram_feedback_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [31:0] a_all();
        return 32'({a_if.ifm_rd_en_o, a_if.ifm_rd_addr_o, a_if.layer_en_o, a_if.busy_o,
                    a_if.done_o, a_if.pix_cnt_o, a_if.err_o});
    endfunction
    function automatic logic [31:0] b_all();
        return 32'({b_if.ifm_rd_en_o, b_if.ifm_rd_addr_o, b_if.layer_en_o, b_if.busy_o,
                    b_if.done_o, b_if.pix_cnt_o, b_if.err_o});
    endfunction

    initial begin
        int first_done, n_done, last_b, max_b, en_b;
        a_if.start_i = 1'b0; a_if.sample_i = 1'b0; a_if.ram_feedback_i = 1'b0;
        b_if.start_i = 1'b0; b_if.sample_i = 1'b0; b_if.ram_feedback_i = 1'b0;

        tv[0]  = v(1,0,0, 1, 0,1,1,0,0);
        tv[1]  = v(0,0,0, 1, 4,1,1,0,0);
        tv[2]  = v(0,0,0, 1, 8,1,1,0,0);
        tv[3]  = v(0,0,0, 1,12,1,1,0,0);
        tv[4]  = v(0,0,0, 0,12,1,1,0,0);
        tv[5]  = v(0,0,0, 1, 1,1,1,0,0);
        tv[6]  = v(0,1,0, 1, 5,1,1,0,1);
        tv[7]  = v(0,0,0, 1, 9,1,1,0,1);
        tv[8]  = v(0,0,0, 1,13,1,1,0,1);
        tv[9]  = v(0,0,0, 0,13,1,1,0,1);
        tv[10] = v(0,0,0, 1, 2,1,1,0,1);
        tv[11] = v(0,1,0, 1, 6,1,1,0,2);
        tv[12] = v(0,0,0, 1,10,1,1,0,2);
        tv[13] = v(0,0,0, 1,14,1,1,0,2);
        tv[14] = v(0,0,0, 0,14,1,1,0,2);
        tv[15] = v(0,0,0, 1, 3,1,1,0,2);
        tv[16] = v(0,1,0, 1, 7,1,1,0,3);
        tv[17] = v(0,0,0, 1,11,1,1,0,3);
        tv[18] = v(0,0,0, 1,15,1,1,0,3);
        tv[19] = v(0,0,0, 0,15,1,1,0,3);
        tv[20] = v(0,0,0, 0,-1,0,1,0,3);
        tv[21] = v(0,1,0, 0,-1,0,1,0,4);
        tv[22] = v(0,0,0, 0,-1,0,1,0,4);
        tv[23] = v(0,0,0, 0,-1,0,1,0,4);
        tv[24] = v(0,0,1, 0,-1,0,1,0,4);
        tv[25] = v(0,0,0, 0,-1,0,0,1,4);
        tv[26] = v(0,0,0, 0,-1,0,0,0,4);

        // reset, then idle with start low
        repeat (3) @(posedge clk);
        #1;
        chk("reset a", a_all(), 0);
        chk("reset b", b_all(), 0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            chk($sformatf("idle%0d busy", i), 32'(a_if.busy_o), 0);
        end
        chk("idle a", a_all(), 0);

        // full layer from the table: address walk, samples, late feedback
        for (int i = 0; i < 27; i++) begin
            cyc(tv[i].st[0], 0, tv[i].sm[0], tv[i].fb[0]);
            chk($sformatf("t%0d rd", i), 32'(a_if.ifm_rd_en_o), tv[i].rd);
            if (tv[i].addr >= 0) chk($sformatf("t%0d addr", i), 32'(a_if.ifm_rd_addr_o), tv[i].addr);
            chk($sformatf("t%0d en", i), 32'(a_if.layer_en_o), tv[i].en);
            chk($sformatf("t%0d busy", i), 32'(a_if.busy_o), tv[i].busy);
            chk($sformatf("t%0d done", i), 32'(a_if.done_o), tv[i].done);
            chk($sformatf("t%0d cnt", i), 32'(a_if.pix_cnt_o), tv[i].cnt);
        end
        chk("table err", 32'(a_if.err_o), 0);

        // early feedback during RUN is latched; done follows the last sample quickly
        cyc(1, 0, 0, 0);
        chk("s4 cnt cleared", 32'(a_if.pix_cnt_o), 0);
        first_done = -1;
        n_done = 0;
        for (int r = 1; r < 30; r++) begin
            cyc(0, 0, (r == 6 || r == 11 || r == 16 || r == 21), r == 3);
            if (a_if.done_o) begin
                n_done++;
                if (first_done < 0) first_done = r;
                chk("s4 busy at done", 32'(a_if.busy_o), 0);
            end
        end
        chk("s4 done cycle", 32'(first_done), 23);
        chk("s4 done pulses", 32'(n_done), 1);
        chk("s4 err", 32'(a_if.err_o), 0);

        // protocol errors
        do_reset();
        cyc(0, 0, 1, 0);
        chk("sample in idle err", 32'(a_if.err_o), 1);
        do_reset();
        chk("err cleared by reset", 32'(a_if.err_o), 0);
        cyc(0, 0, 0, 1);
        chk("feedback in idle err", 32'(a_if.err_o), 1);
        do_reset();
        for (int r = 0; r < 20; r++) begin
            cyc(r == 0 || r == 6, 0, (r >= 2 && r <= 5) || r == 8, 0);
            chk($sformatf("s5 r%0d rd", r), 32'(a_if.ifm_rd_en_o), 32'(e_rd(r, 4)));
            chk($sformatf("s5 r%0d addr", r), 32'(a_if.ifm_rd_addr_o), 32'(e_addr(r, 4, 4)));
            if (r == 7) chk("s5 err before extra", 32'(a_if.err_o), 0);
            if (r == 8) chk("s5 err on extra", 32'(a_if.err_o), 1);
        end
        chk("s5 cnt saturated", 32'(a_if.pix_cnt_o), 4);
        chk("s5 busy", 32'(a_if.busy_o), 1);

        // reset mid-RUN aborts, then both geometries replay from address 0
        do_reset();
        cyc(1, 1, 0, 0);
        for (int r = 1; r < 7; r++) cyc(0, 0, 0, 0);
        chk("pre-abort busy", 32'(a_if.busy_o), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort a", a_all(), 0);
        chk("abort b", b_all(), 0);
        rst = 1'b1;
        last_b = -1;
        max_b = 0;
        en_b = 0;
        for (int r = 0; r < 56; r++) begin
            cyc(r == 0, r == 0, 0, 0);
            en_b += int'(b_if.layer_en_o);
            if (r < 54) begin
                chk($sformatf("b r%0d rd", r), 32'(b_if.ifm_rd_en_o), 32'(e_rd(r, 5)));
                chk($sformatf("b r%0d addr", r), 32'(b_if.ifm_rd_addr_o), 32'(e_addr(r, 5, 9)));
            end
            if (r < 20) begin
                chk($sformatf("a r%0d rd", r), 32'(a_if.ifm_rd_en_o), 32'(e_rd(r, 4)));
                chk($sformatf("a r%0d addr", r), 32'(a_if.ifm_rd_addr_o), 32'(e_addr(r, 4, 4)));
            end
            if (b_if.ifm_rd_en_o) begin
                last_b = int'(b_if.ifm_rd_addr_o);
                if (last_b > max_b) max_b = last_b;
            end
        end
        chk("b last addr", 32'(last_b), 44);
        chk("b max addr", 32'(max_b), 44);
        chk("b run length", 32'(en_b), 54);
        chk("b drain rd", 32'(b_if.ifm_rd_en_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
